// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    // Conversion sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Bits per BCD digit and the shift-and-add-3 correction rule.
    localparam int BCD_W      = 4;
    localparam int ADJ_THRESH = 5;
    localparam int ADJ_ADD    = 3;

    // Width of the bit counter: it must hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    // True when DIGITS decimal digits can represent every WIDTH-bit value.
    function automatic bit digits_ok(input int width, input int digits);
        longint unsigned max_v;
        longint unsigned pow_v;
        max_v = (64'd1 << width) - 64'd1;
        pow_v = 64'd1;
        for (int i = 0; i < digits; i++) begin
            if (pow_v > max_v) return 1'b1;
            pow_v = pow_v * 64'd10;
        end
        return (pow_v > max_v);
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction: add 3 when the digit is 5 or more, no carry out.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [BCD_W-1:0] digit_i,
    output logic [BCD_W-1:0] digit_o
);

    // Pre-shift correction so the following doubling carries into the next digit.
    always_comb begin
        digit_o = digit_i;
        if (digit_i >= BCD_W'(ADJ_THRESH)) begin
            digit_o = digit_i + BCD_W'(ADJ_ADD);
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock.
// Optional macro BIN2BCD_SIGNED_EN: input is two's complement, magnitude is
// converted and the sign is reported on the extra 'neg' output.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [WIDTH-1:0]          bin,
    output logic                      busy,
    output logic                      done,
    output logic [BCD_W*DIGITS-1:0]   bcd
`ifdef BIN2BCD_SIGNED_EN
    ,
    output logic                      neg
`endif
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam int ACC_W = BCD_W * DIGITS;

    // Reject configurations that cannot hold the largest input.
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("bin2bcd_seq: WIDTH must be within 2..32");
    end
    if (!digits_ok(WIDTH, DIGITS)) begin : g_bad_digits
        $error("bin2bcd_seq: DIGITS too small for WIDTH");
    end

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     sr_q, sr_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [ACC_W-1:0]     acc_adj;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ACC_W-1:0]     bcd_q, bcd_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     bin_mag;

`ifdef BIN2BCD_SIGNED_EN
    logic                 sign_q, sign_d;
    logic                 neg_q, neg_d;

    // Magnitude as WIDTH unsigned bits, so the most negative value maps to 2^(WIDTH-1).
    assign bin_mag = bin[WIDTH-1] ? (~bin + WIDTH'(1)) : bin;
    assign neg     = neg_q;
`else
    assign bin_mag = bin;
`endif

    // Every digit is corrected in parallel before each shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (acc_q[BCD_W*g +: BCD_W]),
            .digit_o (acc_adj[BCD_W*g +: BCD_W])
        );
    end

    // Next-state and datapath: accept in IDLE, shift WIDTH times, publish in DONE.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
`ifdef BIN2BCD_SIGNED_EN
        sign_d  = sign_q;
        neg_d   = neg_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = bin_mag;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(WIDTH);
`ifdef BIN2BCD_SIGNED_EN
                    sign_d  = bin[WIDTH-1];
`endif
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // The bit leaving the top digit is always zero and is dropped.
                {acc_d, sr_d} = {acc_adj[ACC_W-2:0], sr_q, 1'b0};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d   = acc_q;
                done_d  = 1'b1;
`ifdef BIN2BCD_SIGNED_EN
                neg_d   = sign_q;
`endif
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
            sign_q  <= 1'b0;
            neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
`ifdef BIN2BCD_SIGNED_EN
            sign_q  <= sign_d;
            neg_q   <= neg_d;
`endif
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq: an 8-bit/3-digit instance and a 5-bit/2-digit instance.
module tb_bin2bcd_seq;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        start8, start5;
    logic [7:0]  bin8;
    logic [4:0]  bin5;
    logic        busy8, busy5, done8, done5;
    logic [11:0] bcd8;
    logic [7:0]  bcd5;
    logic        neg8, neg5;

    int n_checks = 0;
    int n_fail   = 0;
    logic [11:0] exp_q[$];

    bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut8 (
        .clk   (clk),
        .reset (reset),
        .start (start8),
        .bin   (bin8),
        .busy  (busy8),
        .done  (done8),
        .bcd   (bcd8)
`ifdef BIN2BCD_SIGNED_EN
        ,
        .neg   (neg8)
`endif
    );

    bin2bcd_seq #(.WIDTH(5), .DIGITS(2)) dut5 (
        .clk   (clk),
        .reset (reset),
        .start (start5),
        .bin   (bin5),
        .busy  (busy5),
        .done  (done5),
        .bcd   (bcd5)
`ifdef BIN2BCD_SIGNED_EN
        ,
        .neg   (neg5)
`endif
    );

`ifndef BIN2BCD_SIGNED_EN
    assign neg8 = 1'b0;
    assign neg5 = 1'b0;
`endif

    // ---------------- reference model ----------------
    // Decimal digits of the value (magnitude when signed), by plain division.
    function automatic logic [11:0] model_bcd(input int w, input int unsigned v);
        int unsigned mag;
        logic [11:0] r;
        mag = v & ((32'd1 << w) - 32'd1);
`ifdef BIN2BCD_SIGNED_EN
        if (mag >= (32'd1 << (w - 1))) mag = (32'd1 << w) - mag;
`endif
        r = '0;
        for (int i = 0; i < 3; i++) begin
            r[4*i +: 4] = 4'(mag % 10);
            mag = mag / 10;
        end
        return r;
    endfunction

    function automatic logic model_neg(input int w, input int unsigned v);
`ifdef BIN2BCD_SIGNED_EN
        return v[w-1];
`else
        return 1'b0;
`endif
    endfunction

    // ---------------- driver ----------------
    // Issue one start, then observe a bounded window. j counts negedges after the accept edge.
    // extra_j >= 0 pulses a second start on the 8-bit instance at that point.
    task automatic run_conv(input bit sel, input logic [7:0] v, input int extra_j,
                            input logic [7:0] extra_v, output int done_j, output int done_cnt,
                            output int busy_cnt, output logic [11:0] got_bcd, output logic got_neg);
        done_j   = -1;
        done_cnt = 0;
        busy_cnt = 0;
        got_bcd  = '0;
        got_neg  = 1'b0;
        @(negedge clk);
        if (sel) begin start5 = 1'b1; bin5 = v[4:0]; end
        else     begin start8 = 1'b1; bin8 = v;      end
        @(negedge clk);
        start8 = 1'b0;
        start5 = 1'b0;
        bin8   = 8'($urandom);
        bin5   = 5'($urandom);
        for (int j = 0; j <= 16; j++) begin
            if (j > 0) @(negedge clk);
            if (sel ? busy5 : busy8) busy_cnt++;
            if (sel ? done5 : done8) begin
                done_cnt++;
                if (done_j < 0) begin
                    done_j  = j;
                    got_bcd = sel ? {4'h0, bcd5} : bcd8;
                    got_neg = sel ? neg5 : neg8;
                end
            end
            if (j == extra_j) begin
                start8 = 1'b1;
                bin8   = extra_v;
            end else if (j == extra_j + 1) begin
                start8 = 1'b0;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset  = 1'b1;
        start8 = 1'b1;
        start5 = 1'b1;
        bin8   = 8'd55;
        bin5   = 5'd7;
        repeat (3) @(negedge clk);
        n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_busy8 got=%b exp=0", busy8); end
        n_checks++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL reset_done8 got=%b exp=0", done8); end
        n_checks++; if (bcd8 !== 12'h000) begin n_fail++; $display("FAIL reset_bcd8 got=%h exp=000", bcd8); end
        n_checks++; if (busy5 !== 1'b0) begin n_fail++; $display("FAIL reset_busy5 got=%b exp=0", busy5); end
        n_checks++; if (bcd5 !== 8'h00) begin n_fail++; $display("FAIL reset_bcd5 got=%h exp=00", bcd5); end
        n_checks++; if (neg8 !== 1'b0) begin n_fail++; $display("FAIL reset_neg8 got=%b exp=0", neg8); end
        start8 = 1'b0;
        start5 = 1'b0;
        reset  = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_extremes();
        int dj, dc, bc;
        logic [11:0] b;
        logic n;
        run_conv(1'b0, 8'd255, -5, 8'd0, dj, dc, bc, b, n);
        n_checks++; if (dj !== 9) begin n_fail++; $display("FAIL max_done_cycle got=%0d exp=9", dj); end
        n_checks++; if (bc !== 9) begin n_fail++; $display("FAIL max_busy_cycles got=%0d exp=9", bc); end
        n_checks++; if (dc !== 1) begin n_fail++; $display("FAIL max_done_count got=%0d exp=1", dc); end
        n_checks++; if (b !== model_bcd(8, 255)) begin n_fail++; $display("FAIL max_bcd got=%h exp=%h", b, model_bcd(8, 255)); end
        n_checks++; if (n !== model_neg(8, 255)) begin n_fail++; $display("FAIL max_neg got=%b exp=%b", n, model_neg(8, 255)); end
        run_conv(1'b0, 8'd0, -5, 8'd0, dj, dc, bc, b, n);
        n_checks++; if (b !== 12'h000) begin n_fail++; $display("FAIL zero_bcd got=%h exp=000", b); end
        n_checks++; if (dj !== 9) begin n_fail++; $display("FAIL zero_done_cycle got=%0d exp=9", dj); end
    endtask

    task automatic test_random();
        int dj, dc, bc;
        logic [11:0] b, e;
        logic n;
        logic [7:0] v;
        for (int k = 0; k < 16; k++) begin
            v = 8'($urandom_range(0, 255));
            exp_q.push_back(model_bcd(8, v));
            run_conv(1'b0, v, -5, 8'd0, dj, dc, bc, b, n);
            n_checks++; if (dc !== 1) begin n_fail++; $display("FAIL rand_done_count v=%0d got=%0d exp=1", v, dc); end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++; if (b !== e) begin n_fail++; $display("FAIL rand_bcd v=%0d got=%h exp=%h", v, b, e); end
            end
            n_checks++; if (n !== model_neg(8, v)) begin n_fail++; $display("FAIL rand_neg v=%0d got=%b exp=%b", v, n, model_neg(8, v)); end
        end
    endtask

    task automatic test_back_to_back();
        int d_cnt;
        int d_j[4];
        logic [11:0] d_bcd[4];
        d_cnt = 0;
        for (int i = 0; i < 4; i++) begin d_j[i] = -1; d_bcd[i] = '0; end
        @(negedge clk);
        start8 = 1'b1;
        bin8   = 8'd0;
        @(negedge clk);
        bin8 = 8'd100;
        for (int j = 0; j <= 25; j++) begin
            if (j > 0) @(negedge clk);
            if (done8 && d_cnt < 4) begin
                d_j[d_cnt]   = j;
                d_bcd[d_cnt] = bcd8;
                d_cnt++;
            end
            if (j == 9) begin
                n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL b2b_gap_busy got=%b exp=0", busy8); end
            end
            if (j == 10) start8 = 1'b0;
        end
        n_checks++; if (d_cnt !== 2) begin n_fail++; $display("FAIL b2b_done_count got=%0d exp=2", d_cnt); end
        n_checks++; if (d_j[0] !== 9) begin n_fail++; $display("FAIL b2b_first_cycle got=%0d exp=9", d_j[0]); end
        n_checks++; if (d_bcd[0] !== 12'h000) begin n_fail++; $display("FAIL b2b_first_bcd got=%h exp=000", d_bcd[0]); end
        n_checks++; if (d_j[1] - d_j[0] !== 10) begin n_fail++; $display("FAIL b2b_spacing got=%0d exp=10", d_j[1] - d_j[0]); end
        n_checks++; if (d_bcd[1] !== model_bcd(8, 100)) begin n_fail++; $display("FAIL b2b_second_bcd got=%h exp=%h", d_bcd[1], model_bcd(8, 100)); end
    endtask

    task automatic test_ignore_start();
        int dj, dc, bc;
        logic [11:0] b;
        logic n;
        run_conv(1'b0, 8'd77, 3, 8'd42, dj, dc, bc, b, n);
        n_checks++; if (dc !== 1) begin n_fail++; $display("FAIL ignore_done_count got=%0d exp=1", dc); end
        n_checks++; if (b !== model_bcd(8, 77)) begin n_fail++; $display("FAIL ignore_bcd got=%h exp=%h", b, model_bcd(8, 77)); end
        n_checks++; if (dj !== 9) begin n_fail++; $display("FAIL ignore_done_cycle got=%0d exp=9", dj); end
    endtask

    task automatic test_reset_abort();
        int dc, dj, bc;
        logic [11:0] b;
        logic n;
        @(negedge clk);
        start8 = 1'b1;
        bin8   = 8'd200;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", busy8); end
        n_checks++; if (bcd8 !== 12'h000) begin n_fail++; $display("FAIL abort_bcd got=%h exp=000", bcd8); end
        @(negedge clk);
        reset = 1'b0;
        dc = 0;
        for (int j = 0; j < 15; j++) begin
            @(negedge clk);
            if (done8) dc++;
        end
        n_checks++; if (dc !== 0) begin n_fail++; $display("FAIL abort_no_done got=%0d exp=0", dc); end
        run_conv(1'b0, 8'd9, -5, 8'd0, dj, dc, bc, b, n);
        n_checks++; if (b !== 12'h009) begin n_fail++; $display("FAIL abort_next_bcd got=%h exp=009", b); end
    endtask

    task automatic test_sweep5();
        int dj, dc, bc;
        logic [11:0] b;
        logic n;
        for (int v = 0; v < 32; v++) begin
            run_conv(1'b1, 8'(v), -5, 8'd0, dj, dc, bc, b, n);
            n_checks++; if (b !== model_bcd(5, v)) begin n_fail++; $display("FAIL sweep5_bcd v=%0d got=%h exp=%h", v, b, model_bcd(5, v)); end
            n_checks++; if (dj !== 6) begin n_fail++; $display("FAIL sweep5_done_cycle v=%0d got=%0d exp=6", v, dj); end
            n_checks++; if (n !== model_neg(5, v)) begin n_fail++; $display("FAIL sweep5_neg v=%0d got=%b exp=%b", v, n, model_neg(5, v)); end
        end
    endtask

`ifdef BIN2BCD_SIGNED_EN
    task automatic test_signed();
        int dj, dc, bc;
        logic [11:0] b;
        logic n;
        run_conv(1'b0, 8'h80, -5, 8'd0, dj, dc, bc, b, n);
        n_checks++; if (n !== 1'b1) begin n_fail++; $display("FAIL signed_80_neg got=%b exp=1", n); end
        n_checks++; if (b !== 12'h128) begin n_fail++; $display("FAIL signed_80_bcd got=%h exp=128", b); end
        run_conv(1'b0, 8'hFF, -5, 8'd0, dj, dc, bc, b, n);
        n_checks++; if (n !== 1'b1) begin n_fail++; $display("FAIL signed_ff_neg got=%b exp=1", n); end
        n_checks++; if (b !== 12'h001) begin n_fail++; $display("FAIL signed_ff_bcd got=%h exp=001", b); end
        run_conv(1'b0, 8'd127, -5, 8'd0, dj, dc, bc, b, n);
        n_checks++; if (n !== 1'b0) begin n_fail++; $display("FAIL signed_127_neg got=%b exp=0", n); end
        n_checks++; if (b !== 12'h127) begin n_fail++; $display("FAIL signed_127_bcd got=%h exp=127", b); end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        reset  = 1'b1;
        start8 = 1'b0;
        start5 = 1'b0;
        bin8   = '0;
        bin5   = '0;
        test_reset();
        test_extremes();
        test_random();
        test_back_to_back();
        test_ignore_start();
        test_reset_abort();
        test_sweep5();
`ifdef BIN2BCD_SIGNED_EN
        test_signed();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Run-time bound in case the sequence stalls.
    initial begin
        #1ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
